compare_dtw: RTL and testbench
==============================

COMPARE_DTW -- requirements
Module: compare_dtw

Interface
REQ-001 SHALL have parameter SYM_W, default 4, bits per direction symbol.
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum symbols per stroke (power of two); AW = log2(MAX_LEN).
REQ-003 SHALL have parameter SCORE_W, default 8, width of score and SRAM data; SAT = 2^SCORE_W-1.
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_stroke1, i_stroke2  in  SYM_W*MAX_LEN  symbol k = bits [k*SYM_W +: SYM_W].
REQ-007 SHALL have ports i_len1, i_len2  in  AW+1  stroke lengths; legal range 1..MAX_LEN.
REQ-008 SHALL have port i_mode  in  1  0 = equality cost, 1 = circular direction distance.
REQ-009 SHALL have port i_thresh  in  SCORE_W  early-abort threshold.
REQ-010 SHALL have port i_start  in  1  start request, sampled only when idle.
REQ-011 SHALL have port i_dataR  in  SCORE_W  SRAM read data, combinational from same-cycle address.
REQ-012 SHALL have ports o_rw (1, 1=write), o_addr1 (AW, column c), o_addr2 (AW, row r), o_dataW (SCORE_W)  out  SRAM access.
REQ-013 SHALL have ports o_busy, o_done, o_err, o_abort (1 each) and o_score (SCORE_W)  out.

Function
REQ-014 SHALL latch strokes, lengths, mode and thresh on the cycle i_start is accepted in IDLE; i_start while busy SHALL be ignored.
REQ-015 SHALL compute D[c][r], c over stroke1 (0..len1-1), r over stroke2 (0..len2-1), row-major: r outer, c inner.
REQ-016 Cost mode 0: 0 if symbols equal else 1; mode 1: d=|a-b|, cost = min(d, 2^SYM_W-d).
REQ-017 D[c][r] = cost + min(up D[c][r-1], diag D[c-1][r-1], left D[c-1][r]); out-of-range neighbours = SAT; D[0][0] = cost.
REQ-018 Every addition SHALL saturate at SAT; no wrap.
REQ-019 FSM states IDLE, RD_UP, RD_DIAG, WR, FINISH; each cell takes exactly 3 cycles RD_UP->RD_DIAG->WR, including boundary cells (address driven, data ignored).
REQ-020 RD_UP drives addr (c, r-1), RD_DIAG drives (c-1, r-1), o_rw=0; WR drives (c, r), o_rw=1, o_dataW = D[c][r]; left held internally from previous WR of same row.
REQ-021 After WR of (len1-1, len2-1) SHALL enter FINISH: o_score = that value, o_done pulses one cycle, then IDLE; latency start-accept to o_done = 3*len1*len2+1 cycles.
REQ-022 o_score, o_err, o_abort SHALL hold until the next accepted start, which clears them; o_busy high from cycle after accept through FINISH.
REQ-023 len1 or len2 equal 0 or >MAX_LEN SHALL skip computation: o_done next cycle, o_err=1, o_score=SAT, no SRAM writes.
REQ-024 o_rw SHALL be 0 in IDLE and FINISH.

Reset
REQ-025 i_rst SHALL force IDLE and o_busy=0, o_done=0, o_err=0, o_abort=0, o_rw=0, o_score=0, o_addr*=0, o_dataW=0 on next edge, including mid-computation; partial SRAM contents are not restored.
REQ-026 i_rst SHALL take priority over i_start in the same cycle.

Configuration
REQ-027 With COMPARE_DTW_ABORT_EN defined: after WR of the last cell of each row, if row minimum > i_thresh (latched), SHALL go to FINISH with o_score=SAT, o_abort=1.
REQ-028 Without COMPARE_DTW_ABORT_EN: i_thresh ignored, o_abort tied 0, no row-minimum logic.

Structure
REQ-029 Package compare_pkg SHALL hold the FSM state enum, SAT/saturating-add function and mode constants.
REQ-030 Local cost SHALL be a separate combinational sub-module compare_cost (SYM_W parameter, mode input).

Verification
REQ-031 stroke1 all 0xF, stroke2 = all 0xF except symbol 0 = 0x1, len1=3, len2=5, mode 0 -> o_score=1, o_done 46 cycles after accept.
REQ-032 Same stimulus, mode 1 -> o_score=2 (circular distance 14 -> 2), 15 SRAM writes observed.
REQ-033 SCORE_W=4, stroke1 all 0x0, stroke2 all 0x8, len 3x3, mode 1 -> o_score=15 (saturated), no wrap in any written cell.
REQ-034 len1=0, len2=5 -> o_done next cycle, o_err=1, o_score=SAT, o_rw never 1.
REQ-035 i_rst asserted during RD_DIAG of cell (1,1) -> next cycle IDLE, all outputs 0; subsequent start completes correctly.
REQ-036 ABORT_EN, i_thresh=0, stroke1 all 0x1, stroke2 all 0x2, len 4x4, mode 0 -> o_abort=1, o_score=SAT, o_done 13 cycles after accept.

Source files
------------

// File: rtl/compare_pkg.sv
// compare_pkg: shared FSM states, cost-mode constants and saturating arithmetic for compare_dtw.
package compare_pkg;
  typedef enum logic [2:0] {IDLE, RD_UP, RD_DIAG, WR, FINISH} state_e;
  localparam logic MODE_EQ = 1'b0;
  localparam logic MODE_CIRC = 1'b1;
  function automatic logic [31:0] sat_of(input int w);
    return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s;
    logic [32:0] lim;
    s = {1'b0, a} + {1'b0, b};
    lim = {1'b0, sat_of(w)};
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/compare_dtw_if.sv
// compare_dtw_if: score SRAM bus between compare_dtw (master) and the SRAM (slave).
interface compare_dtw_if #(
  parameter int AW = 5,
  parameter int SCORE_W = 8
);
  logic o_rw;
  logic [AW-1:0] o_addr1;
  logic [AW-1:0] o_addr2;
  logic [SCORE_W-1:0] o_dataW;
  logic [SCORE_W-1:0] i_dataR;
  modport master(output o_rw, o_addr1, o_addr2, o_dataW, input i_dataR);
  modport slave(input o_rw, o_addr1, o_addr2, o_dataW, output i_dataR);
endinterface

// File: rtl/compare_cost.sv
// compare_cost: local symbol cost, equality or circular direction distance.
module compare_cost
  import compare_pkg::*;
#(
  parameter int SYM_W = 4
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  input  logic             mode,
  output logic [SYM_W-1:0] cost
);
  logic [SYM_W-1:0] d;
  logic [SYM_W:0] circ;
  always_comb begin
    d = (a > b) ? a - b : b - a;
    circ = {1'b1, {SYM_W{1'b0}}} - {1'b0, d};
    cost = (mode == MODE_CIRC) ? (({1'b0, d} < circ) ? d : circ[SYM_W-1:0]) : SYM_W'(a != b);
  end
endmodule

// File: rtl/compare_dtw.sv
// compare_dtw: DTW distance between two symbol strokes, score matrix kept in external SRAM.
// Define COMPARE_DTW_ABORT_EN to finish early when a whole row exceeds the latched threshold.
module compare_dtw
  import compare_pkg::*;
#(
  parameter int SYM_W = 4,
  parameter int MAX_LEN = 32,
  parameter int SCORE_W = 8,
  localparam int AW = $clog2(MAX_LEN)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [SYM_W*MAX_LEN-1:0] i_stroke1,
  input  logic [SYM_W*MAX_LEN-1:0] i_stroke2,
  input  logic [AW:0]              i_len1,
  input  logic [AW:0]              i_len2,
  input  logic                     i_mode,
  input  logic [SCORE_W-1:0]       i_thresh,
  input  logic                     i_start,
  compare_dtw_if.master            sram,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic                     o_abort,
  output logic [SCORE_W-1:0]       o_score
);
  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(sat_of(SCORE_W));
  state_e state_q, state_d;
  logic [AW-1:0] c_q, c_d, r_q, r_d;
  logic [SYM_W*MAX_LEN-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [AW:0] len1_q, len1_d, len2_q, len2_d;
  logic mode_q, mode_d, err_q, err_d;
  logic [SCORE_W-1:0] up_q, up_d, diag_q, diag_d, left_q, left_d, score_q, score_d;
  logic [SCORE_W-1:0] left_v, best, d_cell;
  logic [SYM_W-1:0] cost;
  logic len_ok, last_c, last_r;
`ifdef COMPARE_DTW_ABORT_EN
  logic [SCORE_W-1:0] thresh_q, thresh_d, rmin_q, rmin_d;
  logic abort_q, abort_d;
`else
  logic unused_thresh;
  assign unused_thresh = ^i_thresh;
`endif
  compare_cost #(.SYM_W(SYM_W)) u_cost (
    .a(s1_q[c_q*SYM_W +: SYM_W]),
    .b(s2_q[r_q*SYM_W +: SYM_W]),
    .mode(mode_q),
    .cost(cost)
  );
  always_comb begin
    len_ok = (i_len1 != '0) && (i_len1 <= (AW+1)'(MAX_LEN)) && (i_len2 != '0) && (i_len2 <= (AW+1)'(MAX_LEN));
    last_c = ({1'b0, c_q} == len1_q - 1'b1);
    last_r = ({1'b0, r_q} == len2_q - 1'b1);
    left_v = (c_q == '0) ? SAT : left_q;
    best = (up_q < diag_q) ? up_q : diag_q;
    best = (best < left_v) ? best : left_v;
    d_cell = (c_q == '0 && r_q == '0) ? SCORE_W'(cost) : SCORE_W'(sat_add(32'(cost), 32'(best), SCORE_W));
  end
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    r_d = r_q;
    s1_d = s1_q;
    s2_d = s2_q;
    len1_d = len1_q;
    len2_d = len2_q;
    mode_d = mode_q;
    up_d = up_q;
    diag_d = diag_q;
    left_d = left_q;
    score_d = score_q;
    err_d = err_q;
`ifdef COMPARE_DTW_ABORT_EN
    thresh_d = thresh_q;
    rmin_d = rmin_q;
    abort_d = abort_q;
`endif
    case (state_q)
      IDLE: if (i_start) begin
        s1_d = i_stroke1;
        s2_d = i_stroke2;
        len1_d = i_len1;
        len2_d = i_len2;
        mode_d = i_mode;
        c_d = '0;
        r_d = '0;
        err_d = !len_ok;
        score_d = len_ok ? '0 : SAT;
        state_d = len_ok ? RD_UP : FINISH;
`ifdef COMPARE_DTW_ABORT_EN
        thresh_d = i_thresh;
        abort_d = 1'b0;
`endif
      end
      RD_UP: begin
        up_d = (r_q == '0) ? SAT : sram.i_dataR;
        state_d = RD_DIAG;
      end
      RD_DIAG: begin
        diag_d = (r_q == '0 || c_q == '0) ? SAT : sram.i_dataR;
        state_d = WR;
      end
      WR: begin
        left_d = d_cell;
        c_d = last_c ? '0 : c_q + 1'b1;
        r_d = last_c ? r_q + 1'b1 : r_q;
        state_d = (last_c && last_r) ? FINISH : RD_UP;
        score_d = (last_c && last_r) ? d_cell : score_q;
`ifdef COMPARE_DTW_ABORT_EN
        rmin_d = (c_q == '0 || d_cell < rmin_q) ? d_cell : rmin_q;
        if (last_c && rmin_d > thresh_q) begin
          state_d = FINISH;
          score_d = SAT;
          abort_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      c_q <= '0;
      r_q <= '0;
      score_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      r_q <= r_d;
      score_q <= score_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge i_clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    len1_q <= len1_d;
    len2_q <= len2_d;
    mode_q <= mode_d;
    up_q <= up_d;
    diag_q <= diag_d;
    left_q <= left_d;
  end
`ifdef COMPARE_DTW_ABORT_EN
  always_ff @(posedge i_clk) begin
    abort_q <= i_rst ? 1'b0 : abort_d;
    thresh_q <= thresh_d;
    rmin_q <= rmin_d;
  end
  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif
  assign sram.o_rw = (state_q == WR);
  assign sram.o_addr1 = (state_q == RD_DIAG) ? c_q - 1'b1 : (state_q == RD_UP || state_q == WR) ? c_q : '0;
  assign sram.o_addr2 = (state_q == RD_UP || state_q == RD_DIAG) ? r_q - 1'b1 : (state_q == WR) ? r_q : '0;
  assign sram.o_dataW = (state_q == WR) ? d_cell : '0;
  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == FINISH);
  assign o_err = err_q;
  assign o_score = score_q;
endmodule

// File: tb/tb_compare_dtw.sv
// tb_compare_dtw: directed vectors against hand-computed DTW scores, latencies and SRAM traffic.
module tb_compare_dtw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [127:0] stroke1, stroke2;
  logic [5:0] len1, len2;
  logic mode, start, start4;
  logic [7:0] thresh;
  logic busy, done, err, abort, busy4, done4, err4, abort4;
  logic [7:0] score;
  logic [3:0] score4;
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int lat, wrs;
  logic [7:0] mem [32][32];
  logic [3:0] mem4 [32][32];
  compare_dtw_if #(.AW(5), .SCORE_W(8)) sb ();
  compare_dtw_if #(.AW(5), .SCORE_W(4)) sb4 ();
  assign sb.i_dataR = mem[sb.o_addr2][sb.o_addr1];
  assign sb4.i_dataR = mem4[sb4.o_addr2][sb4.o_addr1];
  always @(posedge clk) if (sb.o_rw) begin
    mem[sb.o_addr2][sb.o_addr1] <= sb.o_dataW;
    wr_cnt <= wr_cnt + 1;
  end
  always @(posedge clk) if (sb4.o_rw) mem4[sb4.o_addr2][sb4.o_addr1] <= sb4.o_dataW;
  compare_dtw dut (
    .i_clk(clk), .i_rst(rst), .i_stroke1(stroke1), .i_stroke2(stroke2),
    .i_len1(len1), .i_len2(len2), .i_mode(mode), .i_thresh(thresh), .i_start(start),
    .sram(sb), .o_busy(busy), .o_done(done), .o_err(err), .o_abort(abort), .o_score(score)
  );
  compare_dtw #(.SCORE_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_stroke1(stroke1), .i_stroke2(stroke2),
    .i_len1(len1), .i_len2(len2), .i_mode(mode), .i_thresh(4'hF), .i_start(start4),
    .sram(sb4), .o_busy(busy4), .o_done(done4), .o_err(err4), .o_abort(abort4), .o_score(score4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [127:0] s1, input logic [127:0] s2, input logic [5:0] l1,
                     input logic [5:0] l2, input logic m, input logic [7:0] th, input int poke,
                     output int l, output int w);
    int w0;
    @(negedge clk);
    stroke1 = s1;
    stroke2 = s2;
    len1 = l1;
    len2 = l2;
    mode = m;
    thresh = th;
    start = 1'b1;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < 2000) begin
      if (l == poke) begin
        start = 1'b1;
        len1 = 6'd0;
      end
      @(negedge clk);
      start = 1'b0;
      l++;
    end
    w = wr_cnt - w0;
  endtask
  localparam logic [127:0] S_F = {32{4'hF}};
  localparam logic [127:0] S_F1 = {{31{4'hF}}, 4'h1};
  initial begin
    start = 1'b0;
    start4 = 1'b0;
    stroke1 = '0;
    stroke2 = '0;
    len1 = '0;
    len2 = '0;
    mode = 1'b0;
    thresh = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_abort", abort, 0);
    check("rst_score", score, 0);
    check("rst_rw", sb.o_rw, 0);
    check("rst_addr", {sb.o_addr1, sb.o_addr2}, 0);
    check("rst_dataw", sb.o_dataW, 0);
    rst = 1'b0;
    run(S_F, S_F1, 6'd3, 6'd5, 1'b0, 8'hFF, -1, lat, wrs);
    check("eq_lat", lat, 46);
    check("eq_score", score, 1);
    check("eq_err", err, 0);
    check("eq_busy_finish", busy, 1);
    check("eq_writes", wrs, 15);
    @(negedge clk);
    check("eq_idle_busy", busy, 0);
    check("eq_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    check("eq_score_hold", score, 1);
    run(S_F, S_F1, 6'd3, 6'd5, 1'b1, 8'hFF, 5, lat, wrs);
    check("circ_lat", lat, 46);
    check("circ_score", score, 2);
    check("circ_writes", wrs, 15);
    check("circ_err", err, 0);
    run(S_F, S_F1, 6'd0, 6'd5, 1'b0, 8'hFF, -1, lat, wrs);
    check("len0_lat", lat, 1);
    check("len0_err", err, 1);
    check("len0_score", score, 8'hFF);
    check("len0_writes", wrs, 0);
    run(S_F, S_F1, 6'd3, 6'd33, 1'b0, 8'hFF, -1, lat, wrs);
    check("len33_lat", lat, 1);
    check("len33_err", err, 1);
    run(S_F, S_F1, 6'd3, 6'd5, 1'b0, 8'hFF, -1, lat, wrs);
    check("reclr_err", err, 0);
    check("reclr_score", score, 1);
    @(negedge clk);
    stroke1 = S_F;
    stroke2 = S_F1;
    len1 = 6'd3;
    len2 = 6'd5;
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("wr00_rw", sb.o_rw, 1);
    check("wr00_addr", {sb.o_addr1, sb.o_addr2}, 0);
    check("wr00_data", sb.o_dataW, 1);
    repeat (10) @(negedge clk);
    check("up11_rw", sb.o_rw, 0);
    check("up11_addr", {sb.o_addr1, sb.o_addr2}, {5'd1, 5'd0});
    @(negedge clk);
    check("diag11_addr", {sb.o_addr1, sb.o_addr2}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rw", sb.o_rw, 0);
    check("midrst_addr", {sb.o_addr1, sb.o_addr2}, 0);
    check("midrst_dataw", sb.o_dataW, 0);
    run(S_F, S_F1, 6'd3, 6'd5, 1'b0, 8'hFF, -1, lat, wrs);
    check("after_rst_lat", lat, 46);
    check("after_rst_score", score, 1);
    run({32{4'h1}}, {32{4'h2}}, 6'd4, 6'd4, 1'b0, 8'h00, -1, lat, wrs);
`ifdef COMPARE_DTW_ABORT_EN
    check("abort_lat", lat, 13);
    check("abort_flag", abort, 1);
    check("abort_score", score, 8'hFF);
`else
    check("noabort_lat", lat, 49);
    check("noabort_flag", abort, 0);
    check("noabort_score", score, 4);
`endif
    @(negedge clk);
    stroke1 = '0;
    stroke2 = {32{4'h8}};
    len1 = 6'd3;
    len2 = 6'd3;
    mode = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("sat_lat", lat, 28);
    check("sat_score", score4, 15);
    check("sat_err", err4, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("sat_cell_%0d_%0d", c, r), mem4[r][c], (r == 0 && c == 0) ? 8 : 15);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
